// File: rtl/pcpi_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared PCPI coprocessor.
// One transaction at a time: IDLE -> BUSY -> RESP, with an inactivity timeout in BUSY.
module pcpi_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  input  logic [31:0] req0_insn,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  output logic        req0_ready,
  output logic        req0_wr,
  output logic [31:0] req0_rd,
  output logic        req0_wait,

  input  logic        req1_valid,
  input  logic [31:0] req1_insn,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  output logic        req1_ready,
  output logic        req1_wr,
  output logic [31:0] req1_rd,
  output logic        req1_wait,

  output logic        cp_valid,
  output logic [31:0] cp_insn,
  output logic [31:0] cp_rs1,
  output logic [31:0] cp_rs2,
  input  logic        cp_ready,
  input  logic        cp_wr,
  input  logic [31:0] cp_rd,
  input  logic        cp_wait,

  output logic        grant_id,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_grant;
  logic [7:0]  tmo_cnt;
  logic [31:0] rd_q;
  logic        wr_q;
  logic [1:0]  ready_q;
  logic        win;

  // Round-robin pick: contention goes to whoever was not served last.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) win = ~last_grant;
    else if (req1_valid)          win = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      tmo_cnt     <= 8'd0;
      cp_valid    <= 1'b0;
      cp_insn     <= 32'd0;
      cp_rs1      <= 32'd0;
      cp_rs2      <= 32'd0;
      rd_q        <= 32'd0;
      wr_q        <= 1'b0;
      ready_q     <= 2'b00;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q     <= 2'b00;
          timeout_err <= 1'b0;
          if (req0_valid || req1_valid) begin
            grant_id <= win;
            cp_insn  <= win ? req1_insn : req0_insn;
            cp_rs1   <= win ? req1_rs1  : req0_rs1;
            cp_rs2   <= win ? req1_rs2  : req0_rs2;
            tmo_cnt  <= 8'd0;
            cp_valid <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // cp_ready has priority over an expiring timeout.
          if (cp_ready) begin
            rd_q     <= cp_rd;
            wr_q     <= cp_wr;
            ready_q  <= grant_id ? 2'b10 : 2'b01;
            cp_valid <= 1'b0;
            state    <= RESP;
          end else if (cp_wait) begin
            tmo_cnt <= 8'd0;
          end else if (tmo_cnt == TMO_LAST) begin
            rd_q        <= 32'd0;
            wr_q        <= 1'b0;
            ready_q     <= grant_id ? 2'b10 : 2'b01;
            timeout_err <= 1'b1;
            cp_valid    <= 1'b0;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          ready_q     <= 2'b00;
          timeout_err <= 1'b0;
          last_grant  <= grant_id;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign req0_wr    = ready_q[0] & wr_q;
  assign req1_wr    = ready_q[1] & wr_q;
  assign req0_rd    = ready_q[0] ? rd_q : 32'd0;
  assign req1_rd    = ready_q[1] ? rd_q : 32'd0;
  assign req0_wait  = cp_wait & (state == BUSY) & ~grant_id;
  assign req1_wait  = cp_wait & (state == BUSY) &  grant_id;

endmodule

// File: tb/tb_pcpi_arbiter.sv
// Transaction-level bench for pcpi_arbiter: round-robin grants, completion, timeout,
// wait extension, request withdrawal and mid-transaction reset against a reference model.
module tb_pcpi_arbiter;
  localparam int TMO = 16;
  localparam int SLEN = 128;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] rv;
  logic [1:0][31:0] r_insn, r_rs1, r_rs2;
  logic [1:0] o_ready, o_wr, o_wait;
  logic [1:0][31:0] o_rd;
  logic cp_valid, cp_ready, cp_wr, cp_wait;
  logic [31:0] cp_insn, cp_rs1, cp_rs2, cp_rd;
  logic grant_id, busy, timeout_err;

  int errors = 0;
  int checks = 0;
  bit model_last;

  bit          s_rdy [SLEN];
  bit          s_wt  [SLEN];
  bit          s_wr  [SLEN];
  logic [31:0] s_rd  [SLEN];

  pcpi_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_insn(r_insn[0]), .req0_rs1(r_rs1[0]), .req0_rs2(r_rs2[0]),
    .req0_ready(o_ready[0]), .req0_wr(o_wr[0]), .req0_rd(o_rd[0]), .req0_wait(o_wait[0]),
    .req1_valid(rv[1]), .req1_insn(r_insn[1]), .req1_rs1(r_rs1[1]), .req1_rs2(r_rs2[1]),
    .req1_ready(o_ready[1]), .req1_wr(o_wr[1]), .req1_rd(o_rd[1]), .req1_wait(o_wait[1]),
    .cp_valid(cp_valid), .cp_insn(cp_insn), .cp_rs1(cp_rs1), .cp_rs2(cp_rs2),
    .cp_ready(cp_ready), .cp_wr(cp_wr), .cp_rd(cp_rd), .cp_wait(cp_wait),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coprocessor behaviour per BUSY cycle; each entry is idle, wait or ready.
  task automatic sched_clear();
    for (int i = 0; i < SLEN; i++) begin
      s_rdy[i] = 1'b0; s_wt[i] = 1'b0; s_wr[i] = 1'b0; s_rd[i] = $urandom;
    end
    s_rdy[SLEN-1] = 1'b1;
  endtask

  task automatic sched_random();
    sched_clear();
    for (int i = 0; i < SLEN - 1; i++) begin
      int r;
      r = $urandom_range(0, 9);
      s_rdy[i] = (r == 0);
      s_wt[i]  = (r >= 1 && r <= 3);
      s_wr[i]  = $urandom_range(0, 1);
    end
  endtask

  // Ends at the first ready, or once TIMEOUT consecutive idle cycles have elapsed.
  task automatic predict(output int endi, output bit err);
    int run;
    run = 0; endi = SLEN - 1; err = 1'b0;
    for (int i = 0; i < SLEN; i++) begin
      if (s_rdy[i]) begin endi = i; err = 1'b0; return; end
      if (s_wt[i]) run = 0;
      else begin
        run++;
        if (run == TMO) begin endi = i; err = 1'b1; return; end
      end
    end
  endtask

  task automatic run_txn(input bit v0, input bit v1, input bit withdraw, input string tag);
    int w, o, endi;
    bit err;
    logic [31:0] ei, e1, e2, exp_rd;
    bit exp_wr;
    w = (v0 && v1) ? (model_last ? 0 : 1) : (v0 ? 0 : 1);
    o = 1 - w;
    for (int k = 0; k < 2; k++) begin
      r_insn[k] = $urandom; r_rs1[k] = $urandom; r_rs2[k] = $urandom;
    end
    ei = r_insn[w]; e1 = r_rs1[w]; e2 = r_rs2[w];
    rv = {v1, v0};
    predict(endi, err);
    tick();
    checks++;
    if (grant_id !== w[0] || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s grant: grant_id=%0d busy=%0d, required grant_id=%0d busy=1", tag, grant_id, busy, w);
    end
    checks++;
    if (cp_insn !== ei || cp_rs1 !== e1 || cp_rs2 !== e2) begin
      errors++;
      $display("FAIL %s latch: insn=%h rs1=%h rs2=%h, required %h %h %h", tag, cp_insn, cp_rs1, cp_rs2, ei, e1, e2);
    end
    if (withdraw) begin
      rv[w] = 1'b0; r_insn[w] = ~ei; r_rs1[w] = ~e1;
    end
    for (int i = 0; i <= endi; i++) begin
      checks++;
      if (cp_valid !== 1'b1 || o_ready !== 2'b00) begin
        errors++;
        $display("FAIL %s busy_cycle%0d: cp_valid=%0d ready=%b, required 1 and 00", tag, i, cp_valid, o_ready);
      end
      cp_ready = s_rdy[i]; cp_wait = s_wt[i]; cp_rd = s_rd[i]; cp_wr = s_wr[i];
      #1;
      checks++;
      if (o_wait[w] !== s_wt[i] || o_wait[o] !== 1'b0) begin
        errors++;
        $display("FAIL %s wait%0d: wait=%b, granted %0d should be %0d", tag, i, o_wait, w, s_wt[i]);
      end
      tick();
    end
    cp_ready = 1'b0; cp_wait = 1'b0; cp_wr = 1'b1; cp_rd = $urandom;
    exp_rd = err ? 32'd0 : s_rd[endi];
    exp_wr = err ? 1'b0 : s_wr[endi];
    checks++;
    if (o_ready[w] !== 1'b1 || o_ready[o] !== 1'b0 || cp_valid !== 1'b0 || timeout_err !== err) begin
      errors++;
      $display("FAIL %s resp: ready=%b cp_valid=%0d timeout_err=%0d, required ready to %0d, cp_valid=0 timeout_err=%0d",
               tag, o_ready, cp_valid, timeout_err, w, err);
    end
    checks++;
    if (o_rd[w] !== exp_rd || o_wr[w] !== exp_wr || o_rd[o] !== 32'd0 || o_wr[o] !== 1'b0) begin
      errors++;
      $display("FAIL %s data: rd=%h wr=%0d other rd=%h wr=%0d, required rd=%h wr=%0d other 0",
               tag, o_rd[w], o_wr[w], o_rd[o], o_wr[o], exp_rd, exp_wr);
    end
    rv[w] = 1'b0;
    model_last = w[0];
    tick();
    checks++;
    if (o_ready !== 2'b00 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: ready=%b busy=%0d timeout_err=%0d, required 00 0 0", tag, o_ready, busy, timeout_err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, cp_valid, grant_id, timeout_err, o_ready, o_wr, o_wait} !== 10'd0 ||
        cp_insn !== 32'd0 || cp_rs1 !== 32'd0 || cp_rs2 !== 32'd0 || o_rd !== 64'd0) begin
      errors++;
      $display("FAIL %s: busy=%0d cp_valid=%0d grant=%0d terr=%0d ready=%b wr=%b wait=%b insn=%h rs1=%h rs2=%h rd=%h, required all 0",
               tag, busy, cp_valid, grant_id, timeout_err, o_ready, o_wr, o_wait, cp_insn, cp_rs1, cp_rs2, o_rd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rv = 2'b00; cp_ready = 0; cp_wait = 0; cp_wr = 0; cp_rd = 0;
    r_insn = '0; r_rs1 = '0; r_rs2 = '0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    for (int t = 0; t < 4; t++) begin
      sched_clear();
      s_rdy[0] = 1'b1; s_wr[0] = 1'b1;
      run_txn(1'b1, 1'b1, 1'b0, $sformatf("contention%0d", t));
      checks++;
      if (grant_id !== t[0]) begin
        errors++;
        $display("FAIL contention_order%0d: grant_id=%0d, required %0d", t, grant_id, t[0]);
      end
    end
  endtask

  task automatic test_single();
    int endi; bit err;
    sched_clear();
    s_rdy[1] = 1'b1; s_wr[1] = 1'b1; s_rd[1] = 32'hDEAD_BEEF;
    predict(endi, err);
    checks++;
    if (endi !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_model: end=%0d err=%0d, required 1 0", endi, err);
    end
    run_txn(1'b1, 1'b0, 1'b0, "single");
  endtask

  task automatic test_single_fixed_insn();
    sched_clear();
    s_rdy[1] = 1'b1; s_wr[1] = 1'b1; s_rd[1] = 32'hDEAD_BEEF;
    rv = 2'b01; r_insn[0] = 32'h0000_100B;
    tick();
    checks++;
    if (cp_insn !== 32'h0000_100B) begin
      errors++;
      $display("FAIL single_insn: cp_insn=%h, required 0000100b", cp_insn);
    end
    tick();
    cp_ready = 1'b1; cp_wr = 1'b1; cp_rd = 32'hDEAD_BEEF;
    tick();
    cp_ready = 1'b0; cp_wr = 1'b0; cp_rd = 32'd0;
    checks++;
    if (o_ready !== 2'b01 || o_rd[0] !== 32'hDEAD_BEEF || o_wr !== 2'b01 || o_rd[1] !== 32'd0) begin
      errors++;
      $display("FAIL single_resp: ready=%b rd0=%h wr=%b rd1=%h, required 01 deadbeef 01 0", o_ready, o_rd[0], o_wr, o_rd[1]);
    end
    rv = 2'b00;
    model_last = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    sched_clear();
    run_txn(1'b0, 1'b1, 1'b0, "timeout");
  endtask

  task automatic test_wait();
    sched_clear();
    for (int i = 0; i < 40; i++) s_wt[i] = 1'b1;
    s_rdy[40] = 1'b1; s_wr[40] = 1'b1;
    run_txn(1'b1, 1'b0, 1'b0, "wait_ext");
  endtask

  task automatic test_boundary();
    sched_clear();
    s_rdy[TMO-1] = 1'b1; s_wr[TMO-1] = 1'b1;
    run_txn(1'b1, 1'b1, 1'b0, "boundary");
    sched_clear();
    for (int i = 0; i < 10; i++) s_wt[i] = (i == 5);
    run_txn(1'b1, 1'b1, 1'b0, "wait_restart");
  endtask

  task automatic test_withdraw();
    sched_random();
    run_txn(1'b1, 1'b0, 1'b1, "withdraw");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int p;
      p = $urandom_range(1, 3);
      sched_random();
      run_txn(p[0], p[1], $urandom_range(0, 1), $sformatf("rand%0d", t));
    end
  endtask

  task automatic test_reset_mid_busy();
    rv = 2'b01; r_insn[0] = $urandom;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_start: busy=%0d, required 1", busy);
    end
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst_busy");
    rst_n = 1'b1; rv = 2'b00;
    model_last = 1'b1;
    tick();
    check_all_zero("midrst_after");
    sched_clear();
    s_rdy[0] = 1'b1;
    run_txn(1'b0, 1'b1, 1'b0, "midrst_req1");
    // Reset in RESP: no pulse may survive the reset edge.
    sched_clear();
    s_rdy[0] = 1'b1;
    rv = 2'b10;
    tick();
    cp_ready = 1'b1;
    tick();
    cp_ready = 1'b0; rv = 2'b00;
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst_resp");
    rst_n = 1'b1;
    model_last = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_single_fixed_insn();
    test_timeout();
    test_wait();
    test_boundary();
    test_withdraw();
    test_random();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
